spu_prog_loader: RTL and testbench

- Upstream boot stage for the spu.
- Accepts a byte stream over a valid/ready handshake and packs byte pairs into 16-bit instruction words.
- Writes each word into instruction memory, then pulses the spu start input and monitors its stop output.
- Reports done or error, plus the run-cycle count, to the host side.

---
 rtl/spu_prog_loader.sv | 176 +++++++++++++++++
 tb/tb_spu_prog_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spu_prog_loader.sv
// Boot loader for the spu: packs a byte stream into 16-bit words, fills instruction memory,
// starts the spu and watches for stop. Optional checksum word enabled by SPU_LOADER_CHECKSUM_EN.
module spu_prog_loader #(
  parameter int          DEPTH       = 256,
  parameter logic [15:0] RUN_TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [7:0]  im_w_addr,
  output logic [15:0] im_w_data,
  output logic        im_wr,
  output logic        spu_start,
  input  logic        spu_stop,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] run_cycles
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HEADER,
    S_LOAD,
`ifdef SPU_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_START,
    S_ARM,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  logic        phase;
  logic [7:0]  lo_byte;
  logic [8:0]  count;
  logic [8:0]  len;
`ifdef SPU_LOADER_CHECKSUM_EN
  logic [15:0] csum;
`endif

  logic        byte_xfer, word_done, hdr_bad, rdy_state;
  logic [15:0] word, run_next;

  assign byte_xfer = in_valid && in_ready;
  assign word_done = byte_xfer && phase;
  assign word      = {in_data, lo_byte};
  assign hdr_bad   = (word == 16'd0) || (word > 16'(DEPTH));
  assign run_next  = (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;

`ifdef SPU_LOADER_CHECKSUM_EN
  assign rdy_state = (state == S_HEADER) || (state == S_LOAD) || (state == S_CHECK);
`else
  assign rdy_state = (state == S_HEADER) || (state == S_LOAD);
`endif
  // No byte is taken during the write cycle, so a word never overlaps its own write.
  assign in_ready = rdy_state && !im_wr;
  assign busy     = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      phase      <= 1'b0;
      lo_byte    <= '0;
      count      <= '0;
      len        <= '0;
`ifdef SPU_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
      im_wr      <= 1'b0;
      im_w_addr  <= '0;
      im_w_data  <= '0;
      spu_start  <= 1'b0;
      err_code   <= '0;
      run_cycles <= '0;
    end else begin
      im_wr     <= 1'b0;
      spu_start <= 1'b0;
      if (byte_xfer) begin
        phase <= ~phase;
        if (!phase) lo_byte <= in_data;
      end
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load_req) begin
            state      <= S_HEADER;
            count      <= '0;
            phase      <= 1'b0;
`ifdef SPU_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
            err_code   <= '0;
            run_cycles <= '0;
          end
        end
        S_HEADER: begin
          if (word_done) begin
            if (hdr_bad) begin
              state    <= S_ERROR;
              err_code <= 2'd1;
            end else begin
              len   <= word[8:0];
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (word_done) begin
            im_wr     <= 1'b1;
            im_w_addr <= count[7:0];
            im_w_data <= word;
`ifdef SPU_LOADER_CHECKSUM_EN
            csum      <= csum + word;
`endif
          end else if (im_wr) begin
            count <= count + 9'd1;
            if (count + 9'd1 == len) begin
`ifdef SPU_LOADER_CHECKSUM_EN
              state     <= S_CHECK;
`else
              state     <= S_START;
              spu_start <= 1'b1;
`endif
            end
          end
        end
`ifdef SPU_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (word_done) begin
            if (word == csum) begin
              state     <= S_START;
              spu_start <= 1'b1;
            end else begin
              state    <= S_ERROR;
              err_code <= 2'd3;
            end
          end
        end
`endif
        S_START: begin
          run_cycles <= '0;
          state      <= S_ARM;
        end
        // The spu may still report stop from its previous run; wait for it to drop.
        S_ARM: begin
          run_cycles <= run_next;
          if (run_next == RUN_TIMEOUT) begin
            state    <= S_ERROR;
            err_code <= 2'd2;
          end else if (!spu_stop) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          run_cycles <= run_next;
          if (spu_stop) begin
            state <= S_DONE;
          end else if (run_next == RUN_TIMEOUT) begin
            state    <= S_ERROR;
            err_code <= 2'd2;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spu_prog_loader.sv
// Directed bench for spu_prog_loader: write scoreboard, start/stop handshake, errors, reset.
module tb_spu_prog_loader;
  localparam int          DEPTH = 256;
  localparam logic [15:0] TO    = 16'd50;

  logic        clk = 1'b0;
  logic        rst, load_req, in_valid, in_ready, im_wr, spu_start, spu_stop;
  logic        busy, done, err;
  logic [7:0]  in_data, im_w_addr;
  logic [15:0] im_w_data, run_cycles;
  logic [1:0]  err_code;

  int checks = 0, errors = 0, starts = 0, wrs = 0;
  logic [23:0] exp_q[$];
  logic [15:0] prog[$];

  spu_prog_loader #(.DEPTH(DEPTH), .RUN_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_w_addr(im_w_addr), .im_w_data(im_w_data), .im_wr(im_wr),
    .spu_start(spu_start), .spu_stop(spu_stop), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard and start-pulse counter.
  always @(negedge clk) begin : mon
    logic [23:0] e;
    if (!rst && spu_start) starts++;
    if (!rst && im_wr) begin
      wrs++;
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("im_w_addr", 32'(im_w_addr), 32'(e[23:16]));
        chk("im_w_data", 32'(im_w_data), 32'(e[15:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_load();
    load_req = 1'b1; tick(); load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok; int n;
    repeat (gap) tick();
    in_valid = 1'b1; in_data = b; n = 0; ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk); ok = in_ready; tick(); n++;
    end
    in_valid = 1'b0;
    chk("byte_accepted", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [15:0] w, input int maxgap);
    send_byte(w[7:0],  int'($urandom_range(0, maxgap)));
    send_byte(w[15:8], int'($urandom_range(0, maxgap)));
  endtask

  task automatic send_prog(input int maxgap, input bit noisy);
`ifdef SPU_LOADER_CHECKSUM_EN
    logic [15:0] sum;
    sum = '0;
`endif
    send_word(16'(prog.size()), maxgap);
    foreach (prog[i]) begin
      exp_q.push_back({8'(i), prog[i]});
      send_word(prog[i], maxgap);
`ifdef SPU_LOADER_CHECKSUM_EN
      sum = sum + prog[i];
`endif
      if (noisy) pulse_load();
    end
`ifdef SPU_LOADER_CHECKSUM_EN
    send_word(sum, maxgap);
`endif
  endtask

  task automatic wait_start(output bit ok);
    int n;
    ok = 1'b0; n = 0;
    while (!ok && n < 300) begin
      @(negedge clk); ok = spu_start; n++;
    end
    chk("start_seen", 32'(ok), 32'd1);
  endtask

  // Called on the negedge of the start cycle: drop stop one cycle later, raise it 10 after.
  task automatic run_spu();
    int n;
    @(negedge clk);
    chk("start_one_cycle", 32'(spu_start), 32'd0);
    spu_stop = 1'b0;
    repeat (10) @(negedge clk);
    spu_stop = 1'b1;
    n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    chk("done", 32'(done), 32'd1);
    chk("done_err", 32'(err), 32'd0);
    chk("run_cycles", 32'(run_cycles), 32'd11);
  endtask

  initial begin
    bit ok;
    int n, w0, s0;
    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = '0; spu_stop = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_im_wr", 32'(im_wr), 0);
    chk("rst_spu_start", 32'(spu_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_run_cycles", 32'(run_cycles), 0);
    chk("rst_addr", 32'(im_w_addr), 0);
    chk("rst_data", 32'(im_w_data), 0);
    tick(); rst = 1'b0; tick();

    // Basic program, stop initially high from a previous idle state.
    prog = '{16'h1111, 16'h2222, 16'h3333};
    pulse_load();
    chk("busy_header", 32'(busy), 1);
    send_prog(0, 1'b0);
    wait_start(ok);
    chk("writes_before_start", 32'(exp_q.size()), 0);
    run_spu();
    chk("starts_basic", 32'(starts), 1);

    // Bad lengths: zero and DEPTH+1.
    w0 = wrs;
    pulse_load();
    send_word(16'h0000, 0);
    @(negedge clk);
    chk("len0_err", 32'(err), 1);
    chk("len0_code", 32'(err_code), 1);
    chk("len0_in_ready", 32'(in_ready), 0);
    pulse_load();
    chk("len_reload_code", 32'(err_code), 0);
    send_word(16'h0101, 0);
    @(negedge clk);
    chk("len257_err", 32'(err), 1);
    chk("len257_code", 32'(err_code), 1);
    chk("badlen_no_writes", 32'(wrs), 32'(w0));

    // Watchdog: stop stuck low; error lands 50 cycles after the start pulse ends.
    spu_stop = 1'b0;
    prog = '{16'hAAAA, 16'hBBBB};
    pulse_load();
    send_prog(0, 1'b0);
    wait_start(ok);
    @(negedge clk);
    chk("to_start_one_cycle", 32'(spu_start), 0);
    n = 0;
    while (!err && n < 200) begin @(negedge clk); n++; end
    chk("to_latency", 32'(n), 50);
    chk("to_code", 32'(err_code), 2);
    chk("to_run_cycles", 32'(run_cycles), 50);
    chk("to_done", 32'(done), 0);
    chk("starts_to", 32'(starts), 2);

    // Gappy stream with load_req pulses during the load.
    spu_stop = 1'b1;
    prog = '{16'h0B0A, 16'h1D1C, 16'h2F2E, 16'h3130};
    pulse_load();
    send_prog(3, 1'b1);
    wait_start(ok);
    run_spu();
    chk("noisy_writes_left", 32'(exp_q.size()), 0);
    chk("starts_noisy", 32'(starts), 3);

    // Reset between the two bytes of word 1.
    pulse_load();
    send_word(16'h0002, 0);
    send_byte(8'h55, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_im_wr", 32'(im_wr), 0);
    chk("mid_rst_run_cycles", 32'(run_cycles), 0);
    chk("mid_rst_err_code", 32'(err_code), 0);
    tick(); rst = 1'b0; tick();
    prog = '{16'h4444, 16'h5555};
    pulse_load();
    send_prog(1, 1'b0);
    wait_start(ok);
    run_spu();
    chk("starts_after_rst", 32'(starts), 4);

`ifdef SPU_LOADER_CHECKSUM_EN
    // Wrong checksum must not start the spu; the correct one must.
    s0 = starts;
    pulse_load();
    send_word(16'h0002, 0);
    exp_q.push_back({8'd0, 16'h1111}); send_word(16'h1111, 0);
    exp_q.push_back({8'd1, 16'h2222}); send_word(16'h2222, 0);
    send_word(16'h3334, 0);
    repeat (3) @(negedge clk);
    chk("csum_bad_err", 32'(err), 1);
    chk("csum_bad_code", 32'(err_code), 3);
    chk("csum_bad_no_start", 32'(starts), 32'(s0));
    prog = '{16'h1111, 16'h2222};
    pulse_load();
    send_prog(0, 1'b0);
    wait_start(ok);
    run_spu();
    chk("csum_good_starts", 32'(starts), 32'(s0 + 1));
`else
    s0 = starts;
    chk("no_csum_starts", 32'(s0), 4);
`endif

    chk("final_writes_left", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
